// File: rtl/deecho_pkg.sv
`default_nettype none
// ============================================================================
// Module   : deecho_pkg
// Purpose  : Shared definitions for the de-echo block. Holds the FSM state
//            encoding and the default values of the RESOLUTION, DEPTH and
//            SHIFT parameters.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package deecho_pkg;

    // Defaults for the top-level parameters
    localparam int c_RESOLUTION_DEFAULT = 32;
    localparam int c_DEPTH_DEFAULT      = 128;
    localparam int c_SHIFT_DEFAULT      = 2;

    // FILL: history not yet valid, delayed term forced to zero.
    // RUN : the ring holds DEPTH recovered samples, full cancellation active.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } deecho_state_t;

endpackage : deecho_pkg
`default_nettype wire

// File: rtl/deecho_ring.sv
`default_nettype none
// ============================================================================
// Module   : deecho_ring
// Purpose  : DEPTH-entry circular buffer of recovered samples. The read port
//            always addresses the entry at the write pointer, so it presents
//            the sample written DEPTH writes ago. A write and a read of the
//            same entry in one cycle returns the old contents.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset (pointer only)
//            wr_en    - write wr_data at the pointer, then advance it
//            wr_data  - sample to store
//            rd_data  - current contents of the entry at the pointer
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module deecho_ring #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    localparam int               c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    // Pointer wraps explicitly so non-power-of-two depths work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (wr_en) begin
            if (r_wr_ptr == c_PTR_LAST) begin
                r_wr_ptr <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
        end
    end

    // Storage is deliberately not reset; the FILL state masks stale data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Asynchronous read: the write lands at the edge, so a same-cycle read
    // of the written entry sees the previous contents.
    assign rd_data = r_mem[r_wr_ptr];

endmodule : deecho_ring
`default_nettype wire

// File: rtl/deecho.sv
`default_nettype none
// ============================================================================
// Module   : deecho
// Purpose  : Removes a single delayed echo. The input is modelled as
//            y[n] = x[n] + (x[n-DEPTH] << SHIFT); the block recovers
//            x[n] = y[n] - (x[n-DEPTH] << SHIFT) using unsigned modulo
//            arithmetic, feeding its own recovered samples back through a
//            DEPTH-entry ring. One cycle latency, registered output.
// Ports    : clk       - clock, rising edge
//            rst_n     - asynchronous active-low reset
//            enable    - 1: echo removal, 0: bypass (state frozen)
//            in_valid  - qualifies data_in
//            data_in   - echoed sample y[n]
//            out_valid - qualifies data_out (in_valid delayed one cycle)
//            data_out  - recovered sample x[n]
//            primed    - (only with DEECHO_PRIMED_EN) high while in RUN
// Config   : DEECHO_PRIMED_EN - adds the primed output port
// Revision : 1.0 - initial release
// ============================================================================
module deecho
    import deecho_pkg::*;
#(
    parameter int RESOLUTION = c_RESOLUTION_DEFAULT,
    parameter int DEPTH      = c_DEPTH_DEFAULT,
    parameter int SHIFT      = c_SHIFT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [RESOLUTION-1:0] data_in,
    output logic                  out_valid,
`ifdef DEECHO_PRIMED_EN
    output logic [RESOLUTION-1:0] data_out,
    output logic                  primed
`else
    output logic [RESOLUTION-1:0] data_out
`endif
);

    localparam int                 c_CNT_W     = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FILL_LAST = c_CNT_W'(DEPTH - 1);

    deecho_state_t         r_state;
    deecho_state_t         w_state_next;
    logic [c_CNT_W-1:0]    r_fill_cnt;
    logic                  w_accept;
    logic [RESOLUTION-1:0] w_rd_data;
    logic [RESOLUTION-1:0] w_delayed;
    logic [RESOLUTION-1:0] w_scaled;
    logic [RESOLUTION-1:0] w_recovered;
    logic                  w_run;

    // Only enabled, valid samples touch history; enable is ignored otherwise.
    assign w_accept = in_valid & enable;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: begin
                // The sample that makes fill_cnt reach DEPTH enters RUN.
                if (w_accept && (r_fill_cnt == c_FILL_LAST)) begin
                    w_state_next = RUN;
                end
            end
            RUN:     w_state_next = RUN;
            default: w_state_next = FILL;
        endcase
    end

    always_comb begin
        w_run     = (r_state == RUN);
        // Until the ring holds DEPTH real samples, the echo term is zero.
        w_delayed = w_run ? w_rd_data : '0;
    end

    // ---------------------------------------------------------- datapath
    assign w_scaled    = w_delayed << SHIFT;
    assign w_recovered = data_in - w_scaled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt <= '0;
        end else if (w_accept && (r_state == FILL)) begin
            r_fill_cnt <= r_fill_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= enable ? w_recovered : data_in;
            end
        end
    end

    deecho_ring #(
        .WIDTH (RESOLUTION),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_accept),
        .wr_data (w_recovered),
        .rd_data (w_rd_data)
    );

`ifdef DEECHO_PRIMED_EN
    assign primed = w_run;
`endif

endmodule : deecho
`default_nettype wire

// File: tb/tb_deecho.sv
`default_nettype none
// ============================================================================
// Module   : tb_deecho
// Purpose  : Self-checking bench for deecho. A DEPTH=4 instance covers the
//            directed scenarios; a DEPTH=128 instance covers the random
//            round trip against a zero-initialised echo model.
// Ports    : none
// Config   : DEECHO_PRIMED_EN - also checks the primed output
// Revision : 1.0 - initial release
// ============================================================================
module tb_deecho;
    import deecho_pkg::*;

    localparam int c_W    = 32;
    localparam int c_NRT  = 10000;
    localparam int c_DRT  = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           enable, in_valid;
    logic [c_W-1:0] data_in;
    logic           out_valid;
    logic [c_W-1:0] data_out;

    logic           enable_rt, in_valid_rt;
    logic [c_W-1:0] data_in_rt;
    logic           out_valid_rt;
    logic [c_W-1:0] data_out_rt;

`ifdef DEECHO_PRIMED_EN
    logic primed4, primed_rt;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [c_W-1:0] xs [c_NRT];

    deecho #(.RESOLUTION(c_W), .DEPTH(4), .SHIFT(2)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid),
`ifdef DEECHO_PRIMED_EN
        .data_out  (data_out),
        .primed    (primed4)
`else
        .data_out  (data_out)
`endif
    );

    deecho #(.RESOLUTION(c_W), .DEPTH(c_DRT), .SHIFT(2)) dut_rt (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable_rt),
        .in_valid  (in_valid_rt),
        .data_in   (data_in_rt),
        .out_valid (out_valid_rt),
`ifdef DEECHO_PRIMED_EN
        .data_out  (data_out_rt),
        .primed    (primed_rt)
`else
        .data_out  (data_out_rt)
`endif
    );

    // Drive one cycle of stimulus on the small instance; return 1ns after
    // the capturing edge so outputs can be sampled.
    task automatic step(input logic en, input logic v, input logic [c_W-1:0] d);
        @(negedge clk);
        enable   = en;
        in_valid = v;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        enable   = 1'b0;
        data_in  = '0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || data_out !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%0b data=%h, want valid=0 data=0", out_valid, data_out);
        end
        n_vec++;
        if (dut4.r_state !== FILL) begin
            n_err++;
            $display("FAIL reset_state: got %0d, want FILL(0)", dut4.r_state);
        end
`ifdef DEECHO_PRIMED_EN
        n_vec++;
        if (primed4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_primed: got %0b, want 0", primed4);
        end
`endif
        rst_n = 1'b1;
        step(1'b1, 1'b0, 32'h1234);
        n_vec++;
        if (out_valid !== 1'b0 || data_out !== '0) begin
            n_err++;
            $display("FAIL reset_idle: got valid=%0b data=%h, want valid=0 data=0", out_valid, data_out);
        end
    endtask

    task automatic test_fill_cancel;
        logic [c_W-1:0] din [6];
        logic [c_W-1:0] exp [6];
        din = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd4, 32'd0};
        exp = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, din[i]);
            n_vec++;
            if (out_valid !== 1'b1 || data_out !== exp[i]) begin
                n_err++;
                $display("FAIL fill_cancel[%0d]: got valid=%0b data=%h, want valid=1 data=%h", i, out_valid, data_out, exp[i]);
            end
            if (i == 2 || i == 3) begin
                n_vec++;
                if (dut4.r_state !== ((i == 3) ? RUN : FILL)) begin
                    n_err++;
                    $display("FAIL fill_state[%0d]: got %0d, want %0d", i, dut4.r_state, (i == 3) ? 1 : 0);
                end
`ifdef DEECHO_PRIMED_EN
                n_vec++;
                if (primed4 !== ((i == 3) ? 1'b1 : 1'b0)) begin
                    n_err++;
                    $display("FAIL fill_primed[%0d]: got %0b, want %0b", i, primed4, (i == 3));
                end
`endif
            end
        end
    endtask

    task automatic test_modulo_wrap;
        logic [c_W-1:0] din [5];
        logic [c_W-1:0] exp [5];
        din = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        exp = '{32'd1, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, din[i]);
            n_vec++;
            if (out_valid !== 1'b1 || data_out !== exp[i]) begin
                n_err++;
                $display("FAIL modulo_wrap[%0d]: got valid=%0b data=%h, want valid=1 data=%h", i, out_valid, data_out, exp[i]);
            end
        end
    endtask

    task automatic test_bypass_freeze;
        logic [c_W-1:0] din [4];
        din = '{32'd1, 32'd0, 32'd0, 32'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, din[i]);
            n_vec++;
            if (data_out !== din[i]) begin
                n_err++;
                $display("FAIL bypass_prefill[%0d]: got %h, want %h", i, data_out, din[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'd7);
            n_vec++;
            if (out_valid !== 1'b1 || data_out !== 32'd7) begin
                n_err++;
                $display("FAIL bypass[%0d]: got valid=%0b data=%h, want valid=1 data=7", i, out_valid, data_out);
            end
            // Toggling enable while idle must have no effect.
            step(1'b1, 1'b0, 32'd99);
            step(1'b0, 1'b0, 32'd55);
            n_vec++;
            if (out_valid !== 1'b0 || data_out !== 32'd7) begin
                n_err++;
                $display("FAIL bypass_idle[%0d]: got valid=%0b data=%h, want valid=0 data=7", i, out_valid, data_out);
            end
        end
        step(1'b1, 1'b1, 32'd4);
        n_vec++;
        if (out_valid !== 1'b1 || data_out !== 32'd0) begin
            n_err++;
            $display("FAIL bypass_reenable: got valid=%0b data=%h, want valid=1 data=0", out_valid, data_out);
        end
    endtask

    task automatic test_valid_gaps;
        logic [c_W-1:0] din [6];
        logic [c_W-1:0] exp [6];
        din = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd4, 32'd0};
        exp = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, din[i]);
            n_vec++;
            if (out_valid !== 1'b1 || data_out !== exp[i]) begin
                n_err++;
                $display("FAIL gaps[%0d]: got valid=%0b data=%h, want valid=1 data=%h", i, out_valid, data_out, exp[i]);
            end
            for (int j = 0; j < 5; j++) begin
                step(1'b1, 1'b0, 32'hDEAD_BEEF);
                n_vec++;
                if (out_valid !== 1'b0 || data_out !== exp[i]) begin
                    n_err++;
                    $display("FAIL gaps_idle[%0d.%0d]: got valid=%0b data=%h, want valid=0 data=%h", i, j, out_valid, data_out, exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic [c_W-1:0] pre  [4];
        logic [c_W-1:0] post [4];
        pre  = '{32'd1, 32'd0, 32'd0, 32'd5};
        post = '{32'd3, 32'd9, 32'd4, 32'd8};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, pre[i]);
        end
        n_vec++;
        if (out_valid !== 1'b1 || data_out !== 32'd5 || dut4.r_state !== RUN) begin
            n_err++;
            $display("FAIL midreset_pre: got valid=%0b data=%h state=%0d, want valid=1 data=5 state=1", out_valid, data_out, dut4.r_state);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || data_out !== '0 || dut4.r_state !== FILL) begin
            n_err++;
            $display("FAIL midreset_async: got valid=%0b data=%h state=%0d, want valid=0 data=0 state=0", out_valid, data_out, dut4.r_state);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, post[i]);
            n_vec++;
            if (out_valid !== 1'b1 || data_out !== post[i]) begin
                n_err++;
                $display("FAIL midreset_pass[%0d]: got valid=%0b data=%h, want valid=1 data=%h", i, out_valid, data_out, post[i]);
            end
        end
        // History restarts: 4 - (3 << 2) = -8 modulo 2^32.
        step(1'b1, 1'b1, 32'd4);
        n_vec++;
        if (data_out !== 32'hFFFF_FFF8) begin
            n_err++;
            $display("FAIL midreset_cancel: got %h, want fffffff8", data_out);
        end
        step(1'b1, 1'b0, 32'd0);
    endtask

    task automatic test_round_trip;
        logic [c_W-1:0] echo;
        logic [c_W-1:0] past;
        for (int n = 0; n < c_NRT; n++) begin
            xs[n] = $urandom;
        end
        for (int n = 0; n < c_NRT; n++) begin
            past = (n >= c_DRT) ? xs[n - c_DRT] : '0;
            echo = xs[n] + (past << 2);
            @(negedge clk);
            enable_rt   = 1'b1;
            in_valid_rt = 1'b1;
            data_in_rt  = echo;
            @(posedge clk);
            #1;
            n_vec++;
            if (out_valid_rt !== 1'b1 || data_out_rt !== xs[n]) begin
                n_err++;
                $display("FAIL round_trip[%0d]: got valid=%0b data=%h, want valid=1 data=%h", n, out_valid_rt, data_out_rt, xs[n]);
            end
        end
        @(negedge clk);
        in_valid_rt = 1'b0;
    endtask

    initial begin
        enable_rt   = 1'b0;
        in_valid_rt = 1'b0;
        data_in_rt  = '0;
        test_reset();
        test_fill_cancel();
        test_modulo_wrap();
        test_bypass_freeze();
        test_valid_gaps();
        test_reset_midstream();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_deecho
`default_nettype wire
